// File: rtl/fetch_queue_unit.sv
// Decoupled instruction-fetch front end: owns the PC, issues in-order
// requests, buffers {pc, insn} and hands them to decode.
module fetch_queue_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req_valid_out,
  output logic [ADDR_W-1:0]          imem_req_addr_out,
  input  logic                       imem_req_ready_in,
  input  logic                       imem_rsp_valid_in,
  input  logic [DATA_W-1:0]          imem_rsp_data_in,
  input  logic                       redirect_in,
  input  logic [ADDR_W-1:0]          redirect_pc_in,
  output logic                       ins_valid_out,
  output logic [DATA_W-1:0]          ins_out,
  output logic [ADDR_W-1:0]          ins_pc_out,
  output logic [ADDR_W-1:0]          ins_pcn_out,
  input  logic                       ins_ready_in,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t         DEP_C  = cnt_t'(DEPTH);
  localparam logic [CW:0]  DEP_W  = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RPC  = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] qpc_q [DEPTH];
  logic [DATA_W-1:0] qdat_q [DEPTH];
  logic [ADDR_W-1:0] tag_q [DEPTH];
  ptr_t              rd_q, rd_d;
  ptr_t              wr_q, wr_d;
  ptr_t              trd_q, trd_d;
  ptr_t              twr_q, twr_d;
  cnt_t              cnt_q, cnt_d;
  cnt_t              infl_q, infl_d;
  cnt_t              disc_q, disc_d;

  logic [CW:0]       credit;
  logic              req_v;
  logic              fire;
  logic              rsp;
  logic              keep;
  logic              out_v;
  logic              pop;

  // Credit check: live requests plus buffered entries must leave room.
  always_comb begin
    credit = {1'b0, (infl_q - disc_q)} + {1'b0, cnt_q};
    req_v  = reset & ~redirect_in
           & (infl_q < DEP_C) & (credit < DEP_W);
    fire   = req_v & imem_req_ready_in;
    rsp    = imem_rsp_valid_in & (infl_q != '0);
    keep   = rsp & (disc_q == '0) & ~redirect_in;
    out_v  = reset & (cnt_q != '0);
    pop    = out_v & ins_ready_in;
  end

  // Next-state for PC, tag FIFO, in-flight/discard and queue pointers.
  always_comb begin
    pc_d   = pc_q;
    trd_d  = trd_q;
    twr_d  = twr_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    infl_d = infl_q + cnt_t'(fire) - cnt_t'(rsp);
    disc_d = disc_q;
    if (fire) begin
      twr_d = twr_q + ptr_t'(1);
      pc_d  = pc_q + STEP;
    end
    if (rsp) begin
      trd_d = trd_q + ptr_t'(1);
    end
    if (redirect_in) begin
      pc_d   = redirect_pc_in;
      disc_d = infl_q - cnt_t'(rsp);
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
    end else begin
      if (rsp && disc_q != '0) begin
        disc_d = disc_q - cnt_t'(1);
      end
      if (keep) begin
        wr_d = wr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_d = rd_q + ptr_t'(1);
      end
      cnt_d = cnt_q + cnt_t'(keep) - cnt_t'(pop);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q   <= RPC;
      rd_q   <= '0;
      wr_q   <= '0;
      trd_q  <= '0;
      twr_q  <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      trd_q  <= trd_d;
      twr_q  <= twr_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      disc_q <= disc_d;
    end
  end

  // Storage arrays; contents are only observed through valid pointers.
  always_ff @(posedge clock) begin
    if (reset && fire) begin
      tag_q[twr_q] <= pc_q;
    end
    if (reset && keep) begin
      qpc_q[wr_q]  <= tag_q[trd_q];
      qdat_q[wr_q] <= imem_rsp_data_in;
    end
  end

  // Outputs; head fields read as zero when nothing is buffered.
  always_comb begin
    imem_req_valid_out = req_v;
    imem_req_addr_out  = pc_q;
    ins_valid_out      = out_v;
    ins_out            = out_v ? qdat_q[rd_q] : '0;
    ins_pc_out         = out_v ? qpc_q[rd_q] : '0;
    ins_pcn_out        = out_v ? qpc_q[rd_q] + STEP : '0;
    count_out          = reset ? cnt_q : '0;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency
// in-order memory model that answers each address with its inverse.
module tb_fetch_queue_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_v;
  logic [31:0] req_a;
  logic        req_rdy;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = '0;
  logic        redir;
  logic [31:0] redir_pc;
  logic        iv;
  logic [31:0] ins;
  logic [31:0] ipc;
  logic [31:0] ipcn;
  logic        irdy;
  logic [2:0]  cnt;

  int npass = 0;
  int ntot  = 0;
  int mem_lat = 1;
  int cyc = 0;
  int n;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];

  always #5 clock = ~clock;

  fetch_queue_unit dut (
    .clock              (clock),
    .reset              (reset),
    .imem_req_valid_out (req_v),
    .imem_req_addr_out  (req_a),
    .imem_req_ready_in  (req_rdy),
    .imem_rsp_valid_in  (rsp_v),
    .imem_rsp_data_in   (rsp_d),
    .redirect_in        (redir),
    .redirect_pc_in     (redir_pc),
    .ins_valid_out      (iv),
    .ins_out            (ins),
    .ins_pc_out         (ipc),
    .ins_pcn_out        (ipcn),
    .ins_ready_in       (irdy),
    .count_out          (cnt)
  );

  // Memory model: fixed latency, in order, one response per cycle.
  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
      rsp_v <= 1'b0;
    end else begin
      if (req_v && req_rdy) begin
        mq.push_back('{addr: req_a, due: cyc + 1 + mem_lat});
      end
      if (mq.size() != 0 && mq[0].due <= cyc + 2) begin
        rsp_v <= 1'b1;
        rsp_d <= ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        rsp_v <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset(input int lat);
    reset    = 1'b0;
    redir    = 1'b0;
    irdy     = 1'b1;
    mem_lat  = lat;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, output int w);
    w = 0;
    while (!iv && w < maxc) begin
      @(negedge clock);
      w++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    irdy     = 1'b0;
    req_rdy  = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_req_v", {31'b0, req_v}, 32'd0);
    chk("rst_ins_v", {31'b0, iv}, 32'd0);
    chk("rst_cnt", {29'b0, cnt}, 32'd0);
    chk("rst_addr", req_a, 32'h0040_0000);

    // Streaming with a 1-cycle memory.
    irdy  = 1'b1;
    reset = 1'b1;
    #1;
    chk("t1_req_v", {31'b0, req_v}, 32'd1);
    chk("t1_addr0", req_a, 32'h0040_0000);
    @(negedge clock);
    chk("t1_early_v", {31'b0, iv}, 32'd0);
    chk("t1_addr1", req_a, 32'h0040_0004);
    @(negedge clock);
    chk("t1_v", {31'b0, iv}, 32'd1);
    chk("t1_pc", ipc, 32'h0040_0000);
    chk("t1_pcn", ipcn, 32'h0040_0004);
    chk("t1_ins", ins, ~32'h0040_0000);
    @(negedge clock);
    chk("t1_pc2", ipc, 32'h0040_0004);
    chk("t1_cnt", {29'b0, cnt}, 32'd1);

    // Decode stalls: queue fills to DEPTH and requests stop.
    irdy = 1'b0;
    repeat (5) @(negedge clock);
    chk("t2_cnt4", {29'b0, cnt}, 32'd4);
    chk("t2_req_v0", {31'b0, req_v}, 32'd0);
    chk("t2_addr", req_a, 32'h0040_0014);
    chk("t2_head", ipc, 32'h0040_0004);
    irdy = 1'b1;
    #1;
    chk("t2_full_v", {31'b0, req_v}, 32'd0);
    @(negedge clock);
    irdy = 1'b0;
    chk("t2_cnt3", {29'b0, cnt}, 32'd3);
    chk("t2_head2", ipc, 32'h0040_0008);
    chk("t2_req_v1", {31'b0, req_v}, 32'd1);
    @(negedge clock);
    chk("t2_req_v2", {31'b0, req_v}, 32'd0);
    chk("t2_addr2", req_a, 32'h0040_0018);
    chk("t2_cnt3b", {29'b0, cnt}, 32'd3);
    @(negedge clock);
    chk("t2_cnt4b", {29'b0, cnt}, 32'd4);

    // Redirect with two stale requests in a 3-cycle memory.
    do_reset(3);
    repeat (2) @(negedge clock);
    chk("t3_addr", req_a, 32'h0040_0008);
    redir    = 1'b1;
    redir_pc = 32'h0040_0100;
    #1;
    chk("t3_req_v0", {31'b0, req_v}, 32'd0);
    @(negedge clock);
    redir = 1'b0;
    chk("t3_v0", {31'b0, iv}, 32'd0);
    #1;
    chk("t3_req_v1", {31'b0, req_v}, 32'd1);
    chk("t3_addr1", req_a, 32'h0040_0100);
    wait_valid(10, n);
    chk("t3_lat", n, 32'd4);
    chk("t3_pc", ipc, 32'h0040_0100);
    chk("t3_ins", ins, ~32'h0040_0100);

    // Redirect together with a head pop and a live response.
    do_reset(1);
    repeat (2) @(negedge clock);
    chk("t4_v", {31'b0, iv}, 32'd1);
    chk("t4_rsp", {31'b0, rsp_v}, 32'd1);
    redir    = 1'b1;
    redir_pc = 32'h0040_0080;
    #1;
    chk("t4_req_v0", {31'b0, req_v}, 32'd0);
    @(negedge clock);
    redir = 1'b0;
    chk("t4_cnt0", {29'b0, cnt}, 32'd0);
    chk("t4_iv0", {31'b0, iv}, 32'd0);
    #1;
    chk("t4_req_v1", {31'b0, req_v}, 32'd1);
    chk("t4_addr", req_a, 32'h0040_0080);
    wait_valid(10, n);
    chk("t4_lat", n, 32'd2);
    chk("t4_pc", ipc, 32'h0040_0080);

    // Back-to-back redirects: the later target wins.
    do_reset(3);
    repeat (2) @(negedge clock);
    redir    = 1'b1;
    redir_pc = 32'h0040_0200;
    @(negedge clock);
    redir_pc = 32'h0040_0300;
    @(negedge clock);
    redir = 1'b0;
    #1;
    chk("t5_addr", req_a, 32'h0040_0300);
    wait_valid(10, n);
    chk("t5_lat", n, 32'd4);
    chk("t5_pc", ipc, 32'h0040_0300);

    // PC wrap at the top of the address space.
    do_reset(1);
    repeat (2) @(negedge clock);
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    @(negedge clock);
    redir = 1'b0;
    #1;
    chk("t6_req_v", {31'b0, req_v}, 32'd1);
    chk("t6_addr0", req_a, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("t6_addr1", req_a, 32'h0000_0000);
    chk("t6_iv0", {31'b0, iv}, 32'd0);
    @(negedge clock);
    chk("t6_pc", ipc, 32'hFFFF_FFFC);
    chk("t6_pcn", ipcn, 32'h0000_0000);
    chk("t6_ins", ins, 32'h0000_0003);
    @(negedge clock);
    chk("t6_pc2", ipc, 32'h0000_0000);
    chk("t6_pcn2", ipcn, 32'h0000_0004);

    // Reset mid-stream.
    reset = 1'b0;
    #1;
    chk("t7_req_v", {31'b0, req_v}, 32'd0);
    chk("t7_iv", {31'b0, iv}, 32'd0);
    chk("t7_cnt", {29'b0, cnt}, 32'd0);
    @(negedge clock);
    chk("t7_addr", req_a, 32'h0040_0000);
    chk("t7_ins", ins, 32'd0);
    chk("t7_pc", ipc, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end that replaces the single-cycle PC/ROM coupling with a decoupled fetch stage. It owns the PC and issues in-order word requests to an instruction memory of variable latency. Returned instructions are buffered, with their PC, in a DEPTH-entry queue, and presented to decode over a valid/ready handshake. A redirect (jump, branch or register jump) flushes the queue and discards stale in-flight responses.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction word width
DEPTH, 4, queue entries and maximum requests in flight; power of 2, >=2
RESET_PC, 32'h0040_0000, PC loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low
imem_req_valid_out  out  1  fetch request valid
imem_req_addr_out  out  ADDR_W  fetch address (current fetch PC)
imem_req_ready_in  in  1  memory accepts request this cycle
imem_rsp_valid_in  in  1  in-order response valid
imem_rsp_data_in  in  DATA_W  response instruction
redirect_in  in  1  one-cycle redirect strobe
redirect_pc_in  in  ADDR_W  redirect target
ins_valid_out  out  1  queue head valid
ins_out  out  DATA_W  head instruction
ins_pc_out  out  ADDR_W  head PC
ins_pcn_out  out  ADDR_W  head PC + PC_STEP
ins_ready_in  in  1  decode consumes head
count_out  out  log2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (reset==0 at clock edge):
  - fetch PC=RESET_PC; queue empty; inflight=0; discard=0.
  - While reset is low: imem_req_valid_out=0, ins_valid_out=0, count_out=0.
- State:
  - fetch PC.
  - Circular queue with rd/wr pointers and count; each entry holds {pc, data}.
  - inflight: requests issued without a response yet (0..DEPTH).
  - discard: stale requests among inflight (0..inflight).
  - Per-request PC tag FIFO, depth DEPTH.
- Request issue:
  - imem_req_valid_out = reset & !redirect_in & (inflight < DEPTH) & ((inflight - discard) + count < DEPTH).
  - Handshake when valid & ready: push fetch PC to the tag FIFO, inflight++, PC += PC_STEP (wraps modulo 2^ADDR_W).
- Response:
  - On imem_rsp_valid_in: inflight--, pop tag.
  - If discard>0: decrement discard, drop data.
  - Else: enqueue {tag, data}.
  - The credit rule guarantees the queue never overflows. A response with inflight==0 is a protocol error and is ignored.
- Output:
  - ins_valid_out = (count!=0); head fields come from the rd pointer.
  - Pop on ins_valid_out & ins_ready_in.
  - ins_pcn_out = ins_pc_out + PC_STEP (combinational, wraps).
- Redirect (redirect_in==1 at the edge):
  - A head handshake in the same cycle counts as consumed.
  - All remaining queue entries are flushed; count=0.
  - The fetch PC loads redirect_pc_in.
  - discard = inflight after this cycle's response accounting. A response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle. The first request to redirect_pc_in goes out the next cycle.
  - Back-to-back redirects: the last one wins; each recomputes discard.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Reset during outstanding requests clears all state. The memory side must also be reset.
- Latency: with a 1-cycle memory and ins_ready_in held high, the first instruction is valid 2 cycles after reset release. Sustained throughput is 1 instr/cycle.

Test Plan:
- Reset release, 1-cycle memory, ready=1 -> requests at 0x00400000, 0x00400004, ...; first ins_valid 2 cycles after release with ins_pc=0x00400000, ins_pcn=0x00400004; then one instruction per cycle.
- ins_ready_in=0, DEPTH=4 -> exactly 4 requests issued, count_out reaches 4, req_valid stays 0. Release ready for 1 cycle -> one pop, one new request.
- Memory latency 3 with 2 in flight; redirect to 0x00400100 -> both stale responses dropped; next ins_pc=0x00400100; no stale word is ever seen at the output.
- Redirect in the same cycle as a head handshake and a response -> handshake honoured; the response is dropped; count=0 next cycle; no request in the redirect cycle.
- Redirect on consecutive cycles to 0x00400200 then 0x00400300 -> first output ins_pc=0x00400300.
- Fetch PC at 0xFFFFFFFC -> next request address is 0x00000000; ins_pcn_out=0x00000000 for that entry. Reset asserted mid-stream -> all outputs 0 and PC=RESET_PC after the edge.
